pot_scan_seq: RTL and testbench
===============================

POT_SCAN_SEQ -- requirements
Module: pot_scan_seq

Interface
REQ-001 Parameter: TIMEOUT, default 4096, WAIT-state cycles before a conversion is re-issued.
REQ-002 Parameter: GAP_CYC, default 1024, idle cycles between completed scans.
REQ-003 clk  input  1  single system clock; all state on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  scan enable.
REQ-006 a2d_cmplt  input  1  one-cycle pulse from the A2D SPI master: conversion done.
REQ-007 a2d_res  input  12  conversion result; valid in the a2d_cmplt cycle.
REQ-008 strt_cnv  output  1  one-cycle pulse requesting a conversion.
REQ-009 chnnl  output  3  A2D channel for the current conversion; held stable from strt_cnv until a2d_cmplt.
REQ-010 pot_LP, pot_B1, pot_B2, pot_B3, pot_HP, VOLUME  output  12 each  published slide-pot values.
REQ-011 update_req  output  1  new coherent value set available.
REQ-012 update_ack  input  1  consumer has taken the value set.
REQ-013 scan_busy  output  1  high in any state other than IDLE and GAP.
REQ-014 a2d_err  output  1  sticky flag: at least one timeout occurred.

Function
REQ-015 The scan index idx (0..5) SHALL map to chnnl as follows: 0->1 (LP), 1->0 (B1), 2->4 (B2), 3->2 (B3), 4->3 (HP), 5->7 (VOLUME).
REQ-016 The FSM SHALL have the states IDLE, START, WAIT, PUBLISH and GAP.
REQ-017 IDLE: with en=1, go to START with idx=0; with en=0, stay in IDLE.
REQ-018 START: assert strt_cnv for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-019 WAIT: on a2d_cmplt, write a2d_res into shadow[idx]; if idx<5, increment idx and go to START; if idx=5, go to PUBLISH.
REQ-020 WAIT: when the timeout counter reaches TIMEOUT-1 without a2d_cmplt, set a2d_err, go to START, and keep the same idx (retry).
REQ-021 If a2d_cmplt and the timeout occur in the same cycle, a2d_cmplt SHALL win and a2d_err SHALL NOT be set.
REQ-022 a2d_cmplt outside WAIT SHALL be ignored.
REQ-023 On entry to PUBLISH, all six outputs SHALL load from shadow in the same edge and update_req SHALL go high.
REQ-024 Published outputs SHALL change at no other time.
REQ-025 PUBLISH: hold update_req high until update_ack=1 is sampled, then drop update_req and go to GAP.
REQ-026 update_ack while update_req=0 SHALL be ignored.
REQ-027 GAP: count GAP_CYC cycles, then go to IDLE.
REQ-028 en SHALL be sampled only in IDLE; deasserting en mid-scan lets the scan complete and publish.
REQ-029 Timing from en=1 in IDLE: strt_cnv is high on the next cycle.
REQ-030 Timing from a2d_cmplt at cycle N (idx<5): strt_cnv for the next channel is high at N+1.
REQ-031 Timing from a2d_cmplt at cycle N (idx=5): outputs are updated and update_req is high at N+1.
REQ-032 Counters SHALL be wide enough for their parameter values and SHALL NOT wrap within a state.
REQ-033 idx SHALL NOT exceed 5.

Reset
REQ-034 While rst=1, asynchronously:
- state=IDLE, idx=0, counters=0;
- strt_cnv=0, update_req=0, a2d_err=0, chnnl=3'd1;
- pot_LP..pot_HP=12'h800, VOLUME=12'h000, all shadow registers=12'h800.
REQ-035 rst asserted mid-scan or mid-handshake SHALL abort the scan with no partial publish.
REQ-036 After rst deasserts, the block SHALL restart from IDLE.

Verification
REQ-037 Reset check: rst pulse, then en=0 for 100 cycles -> outputs hold reset values, strt_cnv never pulses.
REQ-038 Full scan: en=1, A2D model returns 12'h100*(chnnl+1) with cmplt 40 cycles after strt_cnv, update_ack one cycle after update_req -> chnnl sequence 1,0,4,2,3,7, then:
- pot_LP=12'h200, pot_B1=12'h100, pot_B2=12'h500;
- pot_B3=12'h300, pot_HP=12'h400, VOLUME=12'h800;
- all six outputs change in the same cycle.
REQ-039 Handshake stall: hold update_ack=0 for 500 cycles -> update_req stays high, no strt_cnv, outputs stable; ack -> GAP lasts 1024 cycles, then a new scan starts.
REQ-040 Timeout: suppress cmplt for channel 4 (B2) -> strt_cnv re-issued after 4096 cycles with chnnl=4; a2d_err=1; scan completes normally afterwards.
REQ-041 Boundaries:
- cmplt coincident with the timeout cycle -> no retry, a2d_err stays 0.
- cmplt injected in GAP -> ignored.
- en dropped at the third channel -> scan publishes, then stays in IDLE.
REQ-042 Mid-scan reset: rst during WAIT on idx 3 -> no update_req; outputs return to reset values; after release, the scan restarts at chnnl=1.

Source files
------------

// File: rtl/pot_scan_seq.sv
// Slide-pot scan sequencer: converts six A2D channels in a fixed order, then
// publishes all six values as one coherent set through a req/ack handshake.
module pot_scan_seq #(
    parameter int TIMEOUT = 4096,
    parameter int GAP_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        a2d_cmplt,
    input  logic [11:0] a2d_res,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    output logic [11:0] pot_LP,
    output logic [11:0] pot_B1,
    output logic [11:0] pot_B2,
    output logic [11:0] pot_B3,
    output logic [11:0] pot_HP,
    output logic [11:0] VOLUME,
    output logic        update_req,
    input  logic        update_ack,
    output logic        scan_busy,
    output logic        a2d_err
);
    localparam int CNT_MAX = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_PUBLISH = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    r_idx;
    logic [CW-1:0] r_cnt;
    logic          r_update_req;
    logic          r_a2d_err;

    logic          w_cmplt_wait;
    logic          w_last_idx;
    logic          w_publish;
    logic          w_timeout;
    logic          w_gap_done;
    logic [11:0]   w_pot [6];

    assign w_cmplt_wait = (r_state == S_WAIT) && a2d_cmplt;
    assign w_last_idx   = (r_idx == 3'd5);
    assign w_publish    = w_cmplt_wait && w_last_idx;
    assign w_timeout    = (r_cnt == TO_LAST);
    assign w_gap_done   = (r_cnt == GAP_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= 3'd0;
            r_cnt        <= '0;
            r_update_req <= 1'b0;
            r_a2d_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_idx   <= 3'd0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion in the timeout cycle still counts as success.
                    if (a2d_cmplt) begin
                        if (w_last_idx) begin
                            r_update_req <= 1'b1;
                            r_state      <= S_PUBLISH;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_state <= S_START;
                        end
                    end else if (w_timeout) begin
                        r_a2d_err <= 1'b1;
                        r_state   <= S_START;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PUBLISH: begin
                    if (update_ack) begin
                        r_update_req <= 1'b0;
                        r_idx        <= 3'd0;
                        r_cnt        <= '0;
                        r_state      <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (w_gap_done) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The last result bypasses its shadow so all six outputs load on one edge.
    for (genvar gi = 0; gi < 6; gi++) begin : g_slot
        localparam logic [11:0] RST_POT = (gi == 5) ? 12'h000 : 12'h800;
        logic        w_hit;
        logic [11:0] r_shadow;
        logic [11:0] r_pot;

        assign w_hit = w_cmplt_wait && (r_idx == 3'(gi));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_shadow <= 12'h800;
                r_pot    <= RST_POT;
            end else begin
                if (w_hit) begin
                    r_shadow <= a2d_res;
                end
                if (w_publish) begin
                    r_pot <= w_hit ? a2d_res : r_shadow;
                end
            end
        end

        assign w_pot[gi] = r_pot;
    end

    always_comb begin
        chnnl = 3'd1;
        case (r_idx)
            3'd0: chnnl = 3'd1;
            3'd1: chnnl = 3'd0;
            3'd2: chnnl = 3'd4;
            3'd3: chnnl = 3'd2;
            3'd4: chnnl = 3'd3;
            3'd5: chnnl = 3'd7;
            default: chnnl = 3'd1;
        endcase
    end

    assign strt_cnv   = (r_state == S_START);
    assign scan_busy  = (r_state != S_IDLE) && (r_state != S_GAP);
    assign update_req = r_update_req;
    assign a2d_err    = r_a2d_err;

    assign pot_LP = w_pot[0];
    assign pot_B1 = w_pot[1];
    assign pot_B2 = w_pot[2];
    assign pot_B3 = w_pot[3];
    assign pot_HP = w_pot[4];
    assign VOLUME = w_pot[5];

endmodule

// File: tb/tb_pot_scan_seq.sv
// Scoreboard bench for pot_scan_seq: an A2D responder model predicts the
// published value sets; a monitor checks strt_cnv channels and every publish.
module tb_pot_scan_seq;
    localparam int TIMEOUT = 4096;
    localparam int GAP_CYC = 1024;
    localparam int SEL_STRT = 0;
    localparam int SEL_PUB  = 1;
    localparam int SEL_ACK  = 2;
    localparam logic [71:0] RST_SET = {12'h800, 12'h800, 12'h800, 12'h800, 12'h800, 12'h000};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        a2d_cmplt = 1'b0;
    logic [11:0] a2d_res = 12'h000;
    logic        update_ack = 1'b0;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic [11:0] pot_LP, pot_B1, pot_B2, pot_B3, pot_HP, VOLUME;
    logic        update_req;
    logic        scan_busy;
    logic        a2d_err;

    pot_scan_seq #(.TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC)) dut (
        .clk(clk), .rst(rst), .en(en), .a2d_cmplt(a2d_cmplt), .a2d_res(a2d_res),
        .strt_cnv(strt_cnv), .chnnl(chnnl),
        .pot_LP(pot_LP), .pot_B1(pot_B1), .pot_B2(pot_B2), .pot_B3(pot_B3),
        .pot_HP(pot_HP), .VOLUME(VOLUME),
        .update_req(update_req), .update_ack(update_ack),
        .scan_busy(scan_busy), .a2d_err(a2d_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_strt = 0, n_pub = 0, n_ack = 0;
    int pub_cyc = 0, ack_cyc = 0, en_cyc = 0;
    int strt_cyc_q[$];
    int strt_ch_q[$];
    int exp_ch[$];
    logic [71:0] pub_q[$];
    logic [71:0] last_pub = RST_SET;
    logic [11:0] model_val [8];
    int scan_order [6] = '{1, 0, 4, 2, 3, 7};

    // Responder and handshake knobs
    int lat_default = 40;
    int coincide_ch = -1;
    int suppress_ch = -1;
    bit val_rand = 1'b0;
    int ack_delay = 1;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic chki(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    function automatic logic [71:0] dut_set();
        return {pot_LP, pot_B1, pot_B2, pot_B3, pot_HP, VOLUME};
    endfunction

    function automatic int cnt_of(input int sel);
        if (sel == SEL_STRT) return n_strt;
        if (sel == SEL_PUB) return n_pub;
        return n_ack;
    endfunction

    task automatic wait_until(input string name, input int sel, input int target, input int bound);
        int k = 0;
        while (cnt_of(sel) < target && k < bound) begin
            @(negedge clk);
            k++;
        end
        #1;
        n_chk++;
        if (cnt_of(sel) < target) begin
            n_fail++;
            $display("FAIL %s: actual no event within %0d cycles required event", name, bound);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_scan();
        foreach (scan_order[i]) exp_ch.push_back(scan_order[i]);
    endtask

    task automatic pulse_en();
        @(posedge clk);
        #1 en = 1'b1;
        en_cyc = cyc;
        @(posedge clk);
        #1 en = 1'b0;
    endtask

    task automatic assert_rst();
        @(negedge clk);
        #1 rst = 1'b1;
        exp_ch.delete();
        pub_q.delete();
    endtask

    task automatic release_rst();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // A2D model: answers each strt_cnv after a latency, remembers each channel's value
    initial begin
        int ch, lat;
        bit aborted;
        logic [11:0] v;
        forever begin
            @(negedge clk);
            if (!rst && strt_cnv) begin
                ch = int'(chnnl);
                if (ch == suppress_ch) begin
                    suppress_ch = -1;
                    continue;
                end
                lat = (ch == coincide_ch) ? TIMEOUT : lat_default;
                v = val_rand ? 12'($urandom_range(4095, 0)) : 12'(32'h100 * (ch + 1));
                aborted = 1'b0;
                for (int k = 0; k < lat; k++) begin
                    @(posedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) begin
                    #1;
                    a2d_cmplt = 1'b1;
                    a2d_res = v;
                    model_val[ch] = v;
                    if (ch == 7)
                        pub_q.push_back({model_val[1], model_val[0], model_val[4],
                                         model_val[2], model_val[3], model_val[7]});
                    @(posedge clk);
                    #1 a2d_cmplt = 1'b0;
                end
            end
        end
    end

    // Consumer: acknowledges each new update_req after ack_delay cycles
    initial begin
        logic prev;
        bit rise;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            rise = update_req && !prev;
            prev = update_req;
            if (!rst && rise) begin
                repeat (ack_delay) @(posedge clk);
                #1 update_ack = 1'b1;
                ack_cyc = cyc;
                n_ack++;
                @(posedge clk);
                #1 update_ack = 1'b0;
            end
        end
    end

    // Monitor: pops expected channels on strt_cnv and expected sets on publish
    initial begin
        logic prev_strt, prev_req;
        prev_strt = 1'b0;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_pub = RST_SET;
                prev_strt = 1'b0;
                prev_req = 1'b0;
                chk("reset_outputs", dut_set(), RST_SET);
                continue;
            end
            if (strt_cnv) begin
                chki("strt_pulse_width", int'(prev_strt), 0);
                n_strt++;
                strt_cyc_q.push_back(cyc);
                strt_ch_q.push_back(int'(chnnl));
                if (exp_ch.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_strt: actual strt_cnv chnnl=%0d at cycle %0d required none", chnnl, cyc);
                end else begin
                    chki("strt_chnnl", int'(chnnl), exp_ch.pop_front());
                end
            end
            if (update_req && !prev_req) begin
                n_pub++;
                pub_cyc = cyc;
                if (pub_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_publish: actual update_req at cycle %0d values %0h required none", cyc, dut_set());
                end else begin
                    last_pub = pub_q.pop_front();
                    chk("publish_values", dut_set(), last_pub);
                end
            end else begin
                chk("outputs_stable", dut_set(), last_pub);
            end
            prev_strt = strt_cnv;
            prev_req = update_req;
        end
    end

    initial begin
        #8_000_000;
        $display("FAIL watchdog: actual simulation still running required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0, p0, a0, snap;
        // Reset state, then 100 idle cycles with en=0
        release_rst();
        settle(100);
        #1;
        chki("reset_chnnl", int'(chnnl), 1);
        chki("reset_update_req", int'(update_req), 0);
        chki("reset_a2d_err", int'(a2d_err), 0);
        chki("reset_scan_busy", int'(scan_busy), 0);
        chki("reset_no_strt", n_strt, 0);

        // Full scan with 12'h100*(chnnl+1) values
        val_rand = 1'b0;
        push_scan();
        s0 = n_strt;
        p0 = n_pub;
        pulse_en();
        wait_until("full_scan_publish", SEL_PUB, p0 + 1, 1000);
        chki("en_to_strt", strt_cyc_q[s0] - en_cyc, 1);
        for (int k = 1; k < 6; k++) chki("cmplt_to_next_strt", strt_cyc_q[s0 + k] - strt_cyc_q[s0 + k - 1], 41);
        chki("cmplt_to_publish", pub_cyc - strt_cyc_q[s0 + 5], 41);
        chki("full_pot_LP", int'(pot_LP), 'h200);
        chki("full_pot_B1", int'(pot_B1), 'h100);
        chki("full_pot_B2", int'(pot_B2), 'h500);
        chki("full_pot_B3", int'(pot_B3), 'h300);
        chki("full_pot_HP", int'(pot_HP), 'h400);
        chki("full_VOLUME", int'(VOLUME), 'h800);
        settle(GAP_CYC + 20);

        // Handshake stall of 500 cycles, then GAP length with en held high
        val_rand = 1'b1;
        ack_delay = 500;
        push_scan();
        p0 = n_pub;
        a0 = n_ack;
        @(posedge clk);
        #1 en = 1'b1;
        wait_until("stall_publish", SEL_PUB, p0 + 1, 1000);
        snap = n_strt;
        settle(490);
        #1;
        chki("stall_update_req_held", int'(update_req), 1);
        chki("stall_scan_busy", int'(scan_busy), 1);
        chki("stall_no_strt", n_strt, snap);
        wait_until("stall_ack", SEL_ACK, a0 + 1, 100);
        ack_delay = 1;
        push_scan();
        s0 = n_strt;
        wait_until("gap_restart", SEL_STRT, s0 + 1, GAP_CYC + 100);
        chki("gap_length", strt_cyc_q[s0] - ack_cyc, GAP_CYC + 2);
        @(posedge clk);
        #1 en = 1'b0;
        wait_until("second_scan_publish", SEL_PUB, p0 + 2, 1000);
        settle(GAP_CYC + 20);

        // Timeout on channel 4: retry with same channel, sticky error
        #1;
        chki("err_before_timeout", int'(a2d_err), 0);
        suppress_ch = 4;
        exp_ch = '{1, 0, 4, 4, 2, 3, 7};
        s0 = n_strt;
        p0 = n_pub;
        pulse_en();
        wait_until("timeout_publish", SEL_PUB, p0 + 1, TIMEOUT + 1000);
        chki("timeout_retry_chnnl", strt_ch_q[s0 + 3], 4);
        chki("timeout_retry_spacing", strt_cyc_q[s0 + 3] - strt_cyc_q[s0 + 2], TIMEOUT + 1);
        chki("timeout_err_set", int'(a2d_err), 1);
        settle(GAP_CYC + 20);

        // Clear the sticky error, then cmplt coincident with the timeout cycle
        assert_rst();
        release_rst();
        settle(2);
        #1;
        chki("err_cleared_by_rst", int'(a2d_err), 0);
        coincide_ch = 3;
        push_scan();
        s0 = n_strt;
        p0 = n_pub;
        a0 = n_ack;
        pulse_en();
        wait_until("coincide_publish", SEL_PUB, p0 + 1, TIMEOUT + 1000);
        coincide_ch = -1;
        chki("coincide_next_strt", strt_cyc_q[s0 + 5] - strt_cyc_q[s0 + 4], TIMEOUT + 1);
        chki("coincide_no_err", int'(a2d_err), 0);

        // cmplt and a stray ack injected during GAP and IDLE are ignored
        wait_until("coincide_ack", SEL_ACK, a0 + 1, 100);
        settle(5);
        snap = n_strt;
        @(posedge clk);
        #1 a2d_cmplt = 1'b1;
        a2d_res = 12'($urandom_range(4095, 0));
        update_ack = 1'b1;
        @(posedge clk);
        #1 a2d_cmplt = 1'b0;
        update_ack = 1'b0;
        settle(2);
        #1;
        chki("gap_inject_not_busy", int'(scan_busy), 0);
        settle(GAP_CYC + 20);
        @(posedge clk);
        #1 a2d_cmplt = 1'b1;
        @(posedge clk);
        #1 a2d_cmplt = 1'b0;
        settle(50);
        #1;
        chki("inject_no_strt", n_strt, snap);
        chki("inject_no_err", int'(a2d_err), 0);

        // en dropped at the third channel: scan publishes, then stays idle
        push_scan();
        s0 = n_strt;
        p0 = n_pub;
        a0 = n_ack;
        @(posedge clk);
        #1 en = 1'b1;
        wait_until("third_channel", SEL_STRT, s0 + 3, 500);
        chki("third_channel_chnnl", int'(chnnl), 4);
        @(posedge clk);
        #1 en = 1'b0;
        wait_until("en_drop_publish", SEL_PUB, p0 + 1, 1000);
        wait_until("en_drop_ack", SEL_ACK, a0 + 1, 100);
        settle(GAP_CYC + 300);
        #1;
        chki("en_drop_strt_count", n_strt, s0 + 6);
        chki("en_drop_idle", int'(scan_busy), 0);

        // Reset during WAIT on idx 3: no publish, reset values, restart at chnnl 1
        push_scan();
        s0 = n_strt;
        pulse_en();
        wait_until("mid_rst_idx3", SEL_STRT, s0 + 4, 500);
        settle(10);
        snap = n_pub;
        assert_rst();
        #1;
        chk("mid_rst_outputs", dut_set(), RST_SET);
        chki("mid_rst_chnnl", int'(chnnl), 1);
        chki("mid_rst_update_req", int'(update_req), 0);
        release_rst();
        settle(100);
        #1;
        chki("mid_rst_no_publish", n_pub, snap);
        push_scan();
        s0 = n_strt;
        p0 = n_pub;
        pulse_en();
        wait_until("restart_strt", SEL_STRT, s0 + 1, 50);
        chki("restart_chnnl", strt_ch_q[s0], 1);
        wait_until("restart_publish", SEL_PUB, p0 + 1, 1000);
        settle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
